// File: rtl/backscatter_modulator.sv
// Purpose: drives the RF switch with a phase-keyed square-wave subcarrier while trigger marks a packet (BACKSCATTER_DIFF_EN selects differential phase encoding).
// Latency: MOD is entered START_DELAY clocks after trigger is sampled high; rf_switch lags carrier/phase by one clock.
// Backpressure: none; trigger low aborts on the next edge, and a new packet needs a fresh trigger high after DONE.
module backscatter_modulator #(
    parameter int HALF_PERIOD   = 2,
    parameter int SYMBOL_CYCLES = 50,
    parameter int SAMPLE_OFFSET = 25,
    parameter int START_DELAY   = 50,
    parameter int MAX_BITS      = 144
) (
    input  logic clock,
    input  logic reset,
    input  logic trigger,
    input  logic data_bit,
    output logic rf_switch,
    output logic mod_active,
    output logic done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_MOD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] HP_LAST   = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] SYM_LAST  = 16'(SYMBOL_CYCLES - 1);
    localparam logic [15:0] SAMPLE_AT = 16'(SAMPLE_OFFSET);
    localparam logic [15:0] DLY_LAST  = 16'(START_DELAY - 1);
    localparam logic [15:0] BITS_MAX  = 16'(MAX_BITS);

    state_t      state;
    state_t      next_state;
    logic [15:0] dly_cnt;
    logic [15:0] sc_cnt;
    logic [15:0] sym_cnt;
    logic [15:0] bit_cnt;
    logic        carrier;
    logic        phase;
    logic        sample;

    logic        sym_wrap;
    logic        sample_eff;
    logic        phase_upd;
    logic        rf_switch_nxt;
    logic        mod_active_nxt;
    logic        done_nxt;

    assign sym_wrap = (sym_cnt == SYM_LAST);
    // If the sample point coincides with the wrap, use the live bit so it is not lost.
    assign sample_eff = (sym_cnt == SAMPLE_AT) ? data_bit : sample;

`ifdef BACKSCATTER_DIFF_EN
    assign phase_upd = phase ^ sample_eff;
`else
    assign phase_upd = sample_eff;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; trigger low returns to IDLE from anywhere.
    always_comb begin
        next_state = state;
        if (!trigger) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  next_state = (START_DELAY > 0) ? S_DELAY : S_MOD;
                S_DELAY: if (dly_cnt == DLY_LAST) next_state = S_MOD;
                S_MOD:   if (sym_wrap && (bit_cnt + 16'd1 == BITS_MAX)) next_state = S_DONE;
                S_DONE:  next_state = S_DONE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Output decode from the next state so outputs change on the transition edge.
    always_comb begin
        rf_switch_nxt  = 1'b0;
        mod_active_nxt = 1'b0;
        done_nxt       = 1'b0;
        if (next_state == S_MOD) begin
            rf_switch_nxt  = carrier ^ phase;
            mod_active_nxt = 1'b1;
        end
        if (next_state == S_DONE) begin
            done_nxt = 1'b1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_switch  <= 1'b0;
            mod_active <= 1'b0;
            done       <= 1'b0;
        end else begin
            rf_switch  <= rf_switch_nxt;
            mod_active <= mod_active_nxt;
            done       <= done_nxt;
        end
    end

    // Counters and subcarrier/phase state; cleared whenever heading to IDLE, frozen in DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dly_cnt <= 16'd0;
            sc_cnt  <= 16'd0;
            sym_cnt <= 16'd0;
            bit_cnt <= 16'd0;
            carrier <= 1'b0;
            phase   <= 1'b0;
            sample  <= 1'b0;
        end else if (next_state == S_IDLE) begin
            dly_cnt <= 16'd0;
            sc_cnt  <= 16'd0;
            sym_cnt <= 16'd0;
            bit_cnt <= 16'd0;
            carrier <= 1'b0;
            phase   <= 1'b0;
            sample  <= 1'b0;
        end else if (state == S_DELAY) begin
            dly_cnt <= dly_cnt + 16'd1;
        end else if (state == S_MOD) begin
            if (sc_cnt == HP_LAST) begin
                sc_cnt  <= 16'd0;
                carrier <= ~carrier;
            end else begin
                sc_cnt <= sc_cnt + 16'd1;
            end
            if (sym_wrap) begin
                sym_cnt <= 16'd0;
                phase   <= phase_upd;
                sample  <= 1'b0;
                bit_cnt <= bit_cnt + 16'd1;
            end else begin
                sym_cnt <= sym_cnt + 16'd1;
                if (sym_cnt == SAMPLE_AT) begin
                    sample <= data_bit;
                end
            end
        end
    end

endmodule

// File: doc/backscatter_modulator.md
# backscatter_modulator

Downstream stage of the tag data source. Takes the serial payload bit and, while `trigger` marks an excitation packet, drives the RF switch with a square-wave subcarrier whose phase is flipped per payload symbol. The subcarrier shifts the backscattered 802.11b signal to the adjacent channel. One 1 µs symbol equals `SYMBOL_CYCLES` clocks, matching the data source bit period.

## Interface
- `HALF_PERIOD`, 2: clocks per subcarrier half-period, ≥1.
- `SYMBOL_CYCLES`, 50: clocks per payload symbol, ≥2.
- `SAMPLE_OFFSET`, 25: `sym_cnt` value at which `data_bit` is sampled, less than `SYMBOL_CYCLES`.
- `START_DELAY`, 50: clocks from `trigger` rise to modulation start; 0 is allowed.
- `MAX_BITS`, 144: symbols modulated per packet, ≥1.
- `clock`, in, 1: system clock.
- `reset`, in, 1: reset, asynchronous, active-low. The clock is `clock`.
- `trigger`, in, 1: packet-present envelope, synchronous to `clock`.
- `data_bit`, in, 1: serial payload bit from the data source.
- `rf_switch`, out, 1: RF switch drive, registered.
- `mod_active`, out, 1: high while in MOD.
- `done`, out, 1: high in DONE.

## Operation
- All counters are 16-bit unsigned; no counter may overflow for legal parameters.
- States:
  - IDLE: `rf_switch`, `mod_active` and `done` are 0; all counters are 0; `phase`, `carrier` and `sample` are 0.
  - DELAY: `dly_cnt` increments each cycle.
  - MOD: the modulation state.
  - DONE: the packet is finished.
- Transitions:
  - IDLE to DELAY when `trigger`=1 and `START_DELAY`>0.
  - IDLE to MOD when `trigger`=1 and `START_DELAY`=0.
  - DELAY to MOD when `dly_cnt`==`START_DELAY`-1.
  - MOD to DONE when `bit_cnt` reaches `MAX_BITS`.
  - DONE to IDLE when `trigger`=0.
  - Any state to IDLE when `trigger`=0. This has priority over every other transition.
- Behaviour in MOD:
  - `sc_cnt` counts 0..`HALF_PERIOD`-1; `carrier` toggles on the wrap.
  - `sym_cnt` counts 0..`SYMBOL_CYCLES`-1.
  - When `sym_cnt`==`SAMPLE_OFFSET`, `sample` <= `data_bit`.
  - When `sym_cnt` wraps, the phase update is applied (see Configuration) and `bit_cnt` increments.
  - `rf_switch` <= `carrier` ^ `phase`.
  - The first symbol always uses `phase`=0. The bit sampled in symbol k is applied in symbol k+1.
- Behaviour in DONE: `rf_switch`=0, `mod_active`=0, `done`=1.
- Leaving MOD for any reason: `rf_switch` is forced to 0 on the same edge.

## Timing
- Reset: state is IDLE; every output and every internal register is 0.
- `trigger` rises at edge T0 (sampled 1):
  - With `START_DELAY`=D>0, the state is MOD after edge T0+D.
  - With `START_DELAY`=0, the state is MOD after edge T0.
- `mod_active` is registered. It rises on the same edge that enters MOD and falls on the edge that leaves it.
- `rf_switch` lags `carrier`/`phase` by one clock.
  - First toggle: `carrier` becomes 1 `HALF_PERIOD` clocks after MOD entry, and `rf_switch` follows one clock later.
- The MOD dwell is exactly `MAX_BITS`×`SYMBOL_CYCLES` clocks. DONE is entered on the edge where the final `sym_cnt` wrap makes `bit_cnt`==`MAX_BITS`.
- `trigger` low for even one cycle in DELAY or MOD aborts the packet: IDLE and outputs 0 on the next edge. A new packet needs a fresh `trigger` high.
- `trigger` held high in DONE: the block stays in DONE and does not restart.
- Asynchronous reset mid-packet: immediate IDLE, all outputs 0.

## Configuration
- Macro: `BACKSCATTER_DIFF_EN`.
- Defined: differential encoding. At each symbol wrap, `phase` <= `phase` ^ `sample`; a 1 flips the subcarrier phase relative to the previous symbol.
- Undefined: absolute encoding. At each symbol wrap, `phase` <= `sample`.
- `sample` is cleared to 0 after each wrap in both modes, so a missed sample encodes 0.

## Test plan
- Reset and idle: assert reset mid-MOD with `trigger`=1 -> `rf_switch`, `mod_active` and `done` are 0 within the same cycle. After release with `trigger`=0, all outputs stay 0 for 200 cycles.
- Start delay: `trigger` rises at cycle 10 with defaults -> `mod_active` rises after edge 60. `rf_switch` then shows period-4 toggling: 0,0,1,1,0,0,1,1… after the one-cycle lag.
- Absolute phase (macro undefined): `data_bit` pattern 1,0 per symbol -> `rf_switch` in symbol 2 is inverted versus symbol 1; symbol 3 matches symbol 1.
- Differential phase (macro defined): `data_bit`=1 for every symbol -> the phase inverts at every symbol boundary. `data_bit`=0 -> the phase never changes.
- Packet length: `trigger` held high with defaults -> `mod_active` is high for exactly 7200 cycles, then `done`=1 and `rf_switch`=0 until `trigger` falls. `done` clears the edge after `trigger`=0.
- Abort: `trigger` drops in symbol 10 -> IDLE and `rf_switch`=0 on the next edge. Re-raising `trigger` restarts the delay and `bit_cnt` from 0.
